cplx_mac_acc: RTL and testbench

Parametrised, multi-channel complex multiply-accumulate engine with a per-sample conjugate option and frame-based dump. It uses the 3-multiplier (Gauss) pre-adder form throughout. It keeps NCH time-interleaved accumulators, so several independent correlations or beamforming sums can share one pipeline. It sits after sample alignment and ahead of detection/normalisation logic in the DSP datapath.

---
 rtl/cplx_mac_pkg.sv | 26 ++
 rtl/cplx_mult3.sv | 85 ++++++++
 rtl/cplx_mac_acc.sv | 149 ++++++++++++++
 tb/tb_cplx_mac_acc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cplx_mac_pkg.sv
// Shared constants and types for the cplx_mac_acc complex multiply-accumulate slice.
// Holds the pipeline side-band bundle and the saturation classifier.
package cplx_mac_pkg;

   localparam int unsigned CPLX_MAC_LAT     = 4;
   localparam int unsigned CPLX_MAC_CHW_MAX = 16;

   typedef struct packed {
      logic                        valid;
      logic                        last;
      logic                        conj;
      logic [CPLX_MAC_CHW_MAX-1:0] ch;
   } cplx_mac_sb_t;

   typedef enum logic [1:0] {SatNone, SatPos, SatNeg} cplx_mac_sat_e;

   // The two top bits of a PW+1-bit sum decide whether it fits in PW bits.
   function automatic cplx_mac_sat_e cplx_mac_sat_sel(input logic [1:0] top);
      unique case (top)
         2'b01:   return SatPos;
         2'b10:   return SatNeg;
         default: return SatNone;
      endcase
   endfunction

endpackage

// File: rtl/cplx_mult3.sv
// Stages 1-3 of the complex MAC: input capture with optional conj(b), Gauss pre-adders
// and the three multipliers, with the side-band bundle carried alongside.
module cplx_mult3 import cplx_mac_pkg::*; #(
   parameter int unsigned AW = 18,
   parameter int unsigned BW = 18
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  cplx_mac_sb_t             sb_in,
   input  logic signed [AW-1:0]     ar,
   input  logic signed [AW-1:0]     ai,
   input  logic signed [BW-1:0]     br,
   input  logic signed [BW-1:0]     bi,
   output cplx_mac_sb_t             sb_out,
   output logic signed [AW+BW+1:0]  m0,
   output logic signed [AW+BW+1:0]  mr,
   output logic signed [AW+BW+1:0]  mi
);

   localparam int unsigned MW = AW + BW + 2;
   typedef logic signed [MW-1:0] prod_t;

   cplx_mac_sb_t        sb1_q, sb2_q, sb3_q;
   logic signed [AW-1:0] ar1_q, ai1_q, ar2_q, ai2_q;
   logic signed [BW-1:0] br1_q;
   logic signed [BW:0]   bin_d, bin1_q, bin2_q;
   logic signed [AW:0]   c_d, c_q;
   logic signed [BW+1:0] dr_d, di_d, dr_q, di_q;
   prod_t                m0_d, mr_d, mi_d, m0_q, mr_q, mi_q;

   // Negating in BW+1 bits keeps -2^(BW-1) exact.
   always_comb begin
      bin_d = sb_in.conj ? -$signed({bi[BW-1], bi}) : $signed({bi[BW-1], bi});
      c_d   = $signed({ar1_q[AW-1], ar1_q}) - $signed({ai1_q[AW-1], ai1_q});
      dr_d  = $signed({{2{br1_q[BW-1]}}, br1_q}) - $signed({bin1_q[BW], bin1_q});
      di_d  = $signed({{2{br1_q[BW-1]}}, br1_q}) + $signed({bin1_q[BW], bin1_q});
      m0_d  = prod_t'(bin2_q) * prod_t'(c_q);
      mr_d  = prod_t'(ar2_q) * prod_t'(dr_q);
      mi_d  = prod_t'(ai2_q) * prod_t'(di_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb1_q  <= '0;
         sb2_q  <= '0;
         sb3_q  <= '0;
         ar1_q  <= '0;
         ai1_q  <= '0;
         br1_q  <= '0;
         bin1_q <= '0;
         ar2_q  <= '0;
         ai2_q  <= '0;
         bin2_q <= '0;
         c_q    <= '0;
         dr_q   <= '0;
         di_q   <= '0;
         m0_q   <= '0;
         mr_q   <= '0;
         mi_q   <= '0;
      end else begin
         sb1_q  <= sb_in;
         ar1_q  <= ar;
         ai1_q  <= ai;
         br1_q  <= br;
         bin1_q <= bin_d;
         sb2_q  <= sb1_q;
         ar2_q  <= ar1_q;
         ai2_q  <= ai1_q;
         bin2_q <= bin1_q;
         c_q    <= c_d;
         dr_q   <= dr_d;
         di_q   <= di_d;
         sb3_q  <= sb2_q;
         m0_q   <= m0_d;
         mr_q   <= mr_d;
         mi_q   <= mi_d;
      end
   end

   assign sb_out = sb3_q;
   assign m0     = m0_q;
   assign mr     = mr_q;
   assign mi     = mi_q;

endmodule

// File: rtl/cplx_mac_acc.sv
// Multi-channel complex MAC with frame dump; NCH interleaved accumulators behind one pipeline.
// Define CPLX_MAC_SAT_EN to clamp accumulation and report a sticky per-frame overflow.
module cplx_mac_acc import cplx_mac_pkg::*; #(
   parameter int unsigned AW  = 18,
   parameter int unsigned BW  = 18,
   parameter int unsigned PW  = 58,
   parameter int unsigned NCH = 4,
   parameter int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [CW-1:0]        in_ch,
   input  logic                 in_last,
   input  logic                 conj_b,
   input  logic signed [AW-1:0] ar,
   input  logic signed [AW-1:0] ai,
   input  logic signed [BW-1:0] br,
   input  logic signed [BW-1:0] bi,
   output logic                 out_valid,
   output logic [CW-1:0]        out_ch,
   output logic signed [PW-1:0] pr,
   output logic signed [PW-1:0] pi,
   output logic                 out_ovf
);

   localparam int unsigned MW      = AW + BW + 2;
   localparam logic [CW:0] ChLimit = (CW+1)'(NCH);
   typedef logic signed [PW-1:0] acc_t;

   cplx_mac_sb_t         sb_in, sb3;
   logic signed [MW-1:0] m0, mr, mi;
   logic [CW-1:0]        ch3;
   acc_t                 s_r, s_i, acc_rd_r, acc_rd_i, new_r, new_i;
   acc_t                 acc_r_q [NCH];
   acc_t                 acc_i_q [NCH];
   logic                 out_valid_q;
   logic [CW-1:0]        out_ch_q;
   acc_t                 pr_q, pi_q;
   logic                 unused_sb;

   // Out-of-range channels enter the pipeline as bubbles.
   always_comb begin
      sb_in.valid = in_valid && ({1'b0, in_ch} < ChLimit);
      sb_in.last  = in_last;
      sb_in.conj  = conj_b;
      sb_in.ch    = CPLX_MAC_CHW_MAX'(in_ch);
   end

   cplx_mult3 #(
      .AW (AW),
      .BW (BW)
   ) u_mult (
      .clk    (clk),
      .rst_n  (rst_n),
      .sb_in  (sb_in),
      .ar     (ar),
      .ai     (ai),
      .br     (br),
      .bi     (bi),
      .sb_out (sb3),
      .m0     (m0),
      .mr     (mr),
      .mi     (mi)
   );

   assign ch3       = sb3.ch[CW-1:0];
   assign unused_sb = ^{sb3.conj, sb3.ch[CPLX_MAC_CHW_MAX-1:CW]};
   assign s_r       = acc_t'(m0) + acc_t'(mr);
   assign s_i       = acc_t'(m0) + acc_t'(mi);
   assign acc_rd_r  = acc_r_q[ch3];
   assign acc_rd_i  = acc_i_q[ch3];

`ifdef CPLX_MAC_SAT_EN
   logic signed [PW:0] sum_r, sum_i;
   cplx_mac_sat_e      sel_r, sel_i;
   logic               clamp;
   logic               ovf_q [NCH];
   logic               out_ovf_q;

   function automatic acc_t sat_pick(input cplx_mac_sat_e sel, input acc_t v);
      unique case (sel)
         SatPos:  return {1'b0, {(PW-1){1'b1}}};
         SatNeg:  return {1'b1, {(PW-1){1'b0}}};
         default: return v;
      endcase
   endfunction

   always_comb begin
      sum_r = $signed({acc_rd_r[PW-1], acc_rd_r}) + $signed({s_r[PW-1], s_r});
      sum_i = $signed({acc_rd_i[PW-1], acc_rd_i}) + $signed({s_i[PW-1], s_i});
      sel_r = cplx_mac_sat_sel(sum_r[PW -: 2]);
      sel_i = cplx_mac_sat_sel(sum_i[PW -: 2]);
      new_r = sat_pick(sel_r, sum_r[PW-1:0]);
      new_i = sat_pick(sel_i, sum_i[PW-1:0]);
      clamp = (sel_r != SatNone) || (sel_i != SatNone);
   end

   // The dumped flag includes a clamp on the dumping sample itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) ovf_q[i] <= 1'b0;
         out_ovf_q <= 1'b0;
      end else if (sb3.valid) begin
         ovf_q[ch3] <= ~sb3.last & (ovf_q[ch3] | clamp);
         if (sb3.last) out_ovf_q <= ovf_q[ch3] | clamp;
      end
   end

   assign out_ovf = out_ovf_q;
`else
   always_comb begin
      new_r = acc_rd_r + s_r;
      new_i = acc_rd_i + s_i;
   end

   assign out_ovf = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            acc_r_q[i] <= '0;
            acc_i_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         pr_q        <= '0;
         pi_q        <= '0;
      end else begin
         out_valid_q <= sb3.valid & sb3.last;
         if (sb3.valid) begin
            acc_r_q[ch3] <= sb3.last ? '0 : new_r;
            acc_i_q[ch3] <= sb3.last ? '0 : new_i;
            if (sb3.last) begin
               out_ch_q <= ch3;
               pr_q     <= new_r;
               pi_q     <= new_i;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign pr        = pr_q;
   assign pi        = pi_q;

endmodule

// File: tb/tb_cplx_mac_acc.sv
// Scoreboard bench for cplx_mac_acc: a 4-channel and a 3-channel instance share stimulus,
// so channel 3 exercises the drop path on the smaller one.
module tb_cplx_mac_acc;

   localparam int AW  = 18;
   localparam int BW  = 18;
   localparam int PW  = 40;
   localparam int LAT = 4;
   localparam longint MAXV = (longint'(1) <<< (PW - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (PW - 1));

   typedef struct {
      int     ch;
      longint pr;
      longint pi;
      bit     ovf;
      int     due;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic [1:0]           in_ch = '0;
   logic                 in_last = 1'b0;
   logic                 conj_b = 1'b0;
   logic signed [AW-1:0] ar = '0, ai = '0;
   logic signed [BW-1:0] br = '0, bi = '0;
   logic                 ov4, ov3, ovf4, ovf3;
   logic [1:0]           och4, och3;
   logic signed [PW-1:0] pr4, pi4, pr3, pi3;

   int     cyc = 0;
   int     n_cmp = 0;
   int     n_fail = 0;
   exp_t   q4[$];
   exp_t   q3[$];
   longint acc_r[2][4];
   longint acc_i[2][4];
   bit     ovf_m[2][4];
   int     hold_ch[2];
   longint hold_pr[2];
   longint hold_pi[2];
   bit     hold_ovf[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cplx_mac_acc #(.AW(AW), .BW(BW), .PW(PW), .NCH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_last(in_last),
      .conj_b(conj_b), .ar(ar), .ai(ai), .br(br), .bi(bi),
      .out_valid(ov4), .out_ch(och4), .pr(pr4), .pi(pi4), .out_ovf(ovf4)
   );

   cplx_mac_acc #(.AW(AW), .BW(BW), .PW(PW), .NCH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch), .in_last(in_last),
      .conj_b(conj_b), .ar(ar), .ai(ai), .br(br), .bi(bi),
      .out_valid(ov3), .out_ch(och3), .pr(pr3), .pi(pi3), .out_ovf(ovf3)
   );

   function automatic longint fit(input longint v, output bit c);
      c = 1'b0;
`ifdef CPLX_MAC_SAT_EN
      if (v > MAXV) begin c = 1'b1; return MAXV; end
      if (v < MINV) begin c = 1'b1; return MINV; end
      return v;
`else
      return (v <<< (64 - PW)) >>> (64 - PW);
`endif
   endfunction

   // Reference: plain complex arithmetic, independent of the Gauss factorisation.
   function automatic void model(input int k, input int ch, input bit last, input bit cj,
                                 input int a_r, input int a_i, input int b_r, input int b_i);
      longint bip, sr, si, nr, ni;
      bit     cr, ci;
      exp_t   e;
      if (ch >= ((k == 0) ? 4 : 3)) return;
      bip = cj ? -longint'(b_i) : longint'(b_i);
      sr  = longint'(a_r) * b_r - longint'(a_i) * bip;
      si  = longint'(a_r) * bip + longint'(a_i) * b_r;
      nr  = fit(acc_r[k][ch] + sr, cr);
      ni  = fit(acc_i[k][ch] + si, ci);
      ovf_m[k][ch] = ovf_m[k][ch] | cr | ci;
      if (last) begin
         e = '{ch: ch, pr: nr, pi: ni, ovf: ovf_m[k][ch], due: cyc + LAT};
         if (k == 0) q4.push_back(e);
         else q3.push_back(e);
         acc_r[k][ch] = 0;
         acc_i[k][ch] = 0;
         ovf_m[k][ch] = 1'b0;
      end else begin
         acc_r[k][ch] = nr;
         acc_i[k][ch] = ni;
      end
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < 4; c++) begin
            acc_r[k][c] = 0;
            acc_i[k][c] = 0;
            ovf_m[k][c] = 1'b0;
         end
      q4.delete();
      q3.delete();
   endfunction

   task automatic drive(input int ch, input bit last, input bit cj,
                        input int a_r, input int a_i, input int b_r, input int b_i);
      @(negedge clk);
      in_valid = 1'b1;
      in_ch    = 2'(ch);
      in_last  = last;
      conj_b   = cj;
      ar       = 18'(a_r);
      ai       = 18'(a_i);
      br       = 18'(b_r);
      bi       = 18'(b_i);
      model(0, ch, last, cj, a_r, a_i, b_r, b_i);
      model(1, ch, last, cj, a_r, a_i, b_r, b_i);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int rnd18();
      return int'($urandom_range(0, 262143)) - 131072;
   endfunction

   // Dump cycles pop the scoreboard; other cycles check the outputs hold (zero under reset).
   task automatic check_out(input int k, input bit rn, input bit ov, input int ch,
                            input longint p_r, input longint p_i, input bit ovf);
      exp_t e;
      n_cmp++;
      if (!rn) begin
         hold_ch[k] = 0; hold_pr[k] = 0; hold_pi[k] = 0; hold_ovf[k] = 1'b0;
      end
      if (ov && rn) begin
         if ((k == 0 && q4.size() == 0) || (k == 1 && q3.size() == 0)) begin
            n_fail++;
            $display("FAIL dut%0d unexpected dump: ch=%0d pr=%0d pi=%0d, required no dump",
                     k, ch, p_r, p_i);
         end else begin
            if (k == 0) e = q4.pop_front();
            else e = q3.pop_front();
            if (e.ch != ch || e.pr != p_r || e.pi != p_i || e.ovf != ovf || e.due != cyc) begin
               n_fail++;
               $display("FAIL dut%0d dump: ch=%0d pr=%0d pi=%0d ovf=%0d cyc=%0d, required ch=%0d pr=%0d pi=%0d ovf=%0d cyc=%0d",
                        k, ch, p_r, p_i, ovf, cyc, e.ch, e.pr, e.pi, e.ovf, e.due);
            end
            hold_ch[k] = e.ch; hold_pr[k] = e.pr; hold_pi[k] = e.pi; hold_ovf[k] = e.ovf;
         end
      end else if (ov || ch != hold_ch[k] || p_r != hold_pr[k] || p_i != hold_pi[k] ||
                   ovf != hold_ovf[k]) begin
         n_fail++;
         $display("FAIL dut%0d hold rst_n=%0d: valid=%0d ch=%0d pr=%0d pi=%0d ovf=%0d, required valid=0 ch=%0d pr=%0d pi=%0d ovf=%0d",
                  k, rn, ov, ch, p_r, p_i, ovf, hold_ch[k], hold_pr[k], hold_pi[k], hold_ovf[k]);
      end
   endtask

   always @(negedge clk) begin
      check_out(0, rst_n, ov4, int'(och4), longint'(pr4), longint'(pi4), ovf4);
      check_out(1, rst_n, ov3, int'(och3), longint'(pr3), longint'(pi3), ovf3);
   end

   initial begin
      model_reset();
      for (int k = 0; k < 2; k++) begin
         hold_ch[k] = 0; hold_pr[k] = 0; hold_pi[k] = 0; hold_ovf[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Single-sample frames, plain and conjugated: (23,14) then (7,26).
      drive(0, 1, 0, 3, 4, 5, -2);
      idle(5);
      drive(0, 1, 1, 3, 4, 5, -2);
      idle(5);

      // Interleaved ch1/ch2 frames with back-to-back ch2, run twice to see the restart.
      for (int r = 0; r < 2; r++) begin
         drive(1, 0, 0, 1, 0, 1, 1);
         drive(2, 0, 0, 1, 0, 2, -1);
         drive(1, 0, 0, 1, 0, 1, 1);
         drive(2, 0, 0, 1, 0, 2, -1);
         drive(2, 1, 0, 1, 0, 2, -1);
         drive(1, 1, 0, 1, 0, 1, 1);
      end
      idle(6);

      // 32 x 2^34 on ch3 reaches 2^39: clamps or wraps; the 3-channel instance drops it all.
      for (int n = 0; n < 32; n++) drive(3, n == 31, 0, -131072, 0, -131072, 0);
      drive(0, 1, 0, 1, 0, 1, 0);
      idle(6);

      // Reset mid-frame, then a single fresh sample.
      drive(3, 0, 0, 5, 5, 7, 7);
      drive(3, 0, 0, 9, 1, 2, 3);
      pulse_reset();
      drive(3, 1, 0, 2, 0, 3, 0);
      idle(6);

      // Conjugate of the most negative bi must be exact.
      drive(1, 1, 1, 1, 0, 0, -131072);
      drive(2, 1, 1, -131072, -131072, -131072, -131072);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) idle(1);
         else drive(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1, rnd18(), rnd18(), rnd18(), rnd18());
      end
      for (int c = 0; c < 4; c++) drive(c, 1, 0, 0, 0, 0, 0);
      idle(10);

      @(posedge clk);
      #1;
      n_cmp++;
      if (q4.size() != 0) begin
         n_fail++;
         $display("FAIL dut0 drain: %0d dumps outstanding, required 0", q4.size());
      end
      n_cmp++;
      if (q3.size() != 0) begin
         n_fail++;
         $display("FAIL dut1 drain: %0d dumps outstanding, required 0", q3.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
